// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// optional two's-complement input, sign/magnitude output and digit count.
//
// state  | meaning
// IDLE   | waiting for start; result outputs held
// SHIFT  | one add-3/shift iteration per cycle, W cycles
// FINISH | scratch holds final BCD; publish result and pulse done
module bcd_seq_converter #(
  parameter int W = 18,
  parameter int SIGNED = 1,
  localparam int NBCD = W + (W - 4) / 3 + 1,
  localparam int ND = (NBCD + 3) / 4,
  localparam int NDW = $clog2(ND + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [NBCD-1:0] bcd,
  output logic            sign,
  output logic [NDW-1:0]  ndig
);

  localparam int SW = 4 * ND;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   scratch;
  logic [W-1:0]    mag;
  logic            neg;
  logic            in_neg;
  logic [CW-1:0]   cnt;
  logic [NDW-1:0]  ndig_c;

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < ND; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign in_neg = (SIGNED != 0) && bin[W-1];
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Significant digits: highest nonzero digit index + 1, minimum 1.
  always_comb begin
    ndig_c = NDW'(1);
    for (int i = 0; i < ND; i++) begin
      if (scratch[4*i +: 4] != 4'd0) ndig_c = NDW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      mag     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd     <= '0;
      sign    <= 1'b0;
      ndig    <= NDW'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg     <= in_neg;
            mag     <= in_neg ? (~bin + W'(1)) : bin;
            scratch <= '0;
            cnt     <= CW'(W);
          end
        end
        SHIFT: begin
          {scratch, mag} <= {add3(scratch), mag} << 1;
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          bcd  <= scratch[NBCD-1:0];
          // A zero magnitude never reports negative.
          sign <= neg && (scratch != '0);
          ndig <= ndig_c;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
